// File: rtl/ssy_arb_pkg.sv
// Shared types and constants for the round-robin grant scheduler.
//   state_e   : scheduler state encoding (IDLE / SETUP / GRANT)
//   DEF_*     : default setup and grant lengths in cycles
//   cnt_width : width of the phase down-counter for given setup/hold lengths
package ssy_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  localparam int unsigned DEF_SETUP_CYCLES = 2;
  localparam int unsigned DEF_HOLD_CYCLES  = 1;

  // Counter must hold max(setup, hold) - 1; sized as clog2(max + 1).
  function automatic int unsigned cnt_width(input int unsigned setup_cycles,
                                            input int unsigned hold_cycles);
    int unsigned m;
    m = (setup_cycles > hold_cycles) ? setup_cycles : hold_cycles;
    return $clog2(m + 32'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: finds the first set request starting at ptr and
// wrapping modulo NUM_REQ.
//   req      : request vector
//   ptr      : index searched first
//   any_c    : at least one request is set
//   winner_c : index of the selected request (0 when none)
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any_c,
  output logic [$clog2(NUM_REQ)-1:0] winner_c
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  int unsigned idx;

  // Walk the ring from ptr; the first hit wins.
  always_comb begin
    any_c    = 1'b0;
    winner_c = '0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_c && req[IDW'(idx)]) begin
        any_c    = 1'b1;
        winner_c = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin scheduler for one single-owner resource with a fixed
// request -> setup -> grant -> idle handshake. Arbitration only in IDLE.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : level request per requester
//   done         : early release by the owner, honoured only in GRANT
//   gnt          : one-hot grant, high only in GRANT
//   gnt_id       : index of current or last owner
//   busy / idle  : SETUP-or-GRANT / IDLE status
module rr_grant_sched
  import ssy_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       done,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       idle
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = cnt_width(SETUP_CYCLES, HOLD_CYCLES);

  state_e             state;
  logic [IDW-1:0]     owner;
  logic [IDW-1:0]     ptr;
  logic [CW-1:0]      cnt;
  logic [NUM_REQ-1:0] gnt_q;
  logic               busy_q;
  logic               idle_q;

  logic               pick_any_c;
  logic [IDW-1:0]     pick_id_c;
  logic [IDW-1:0]     ptr_next_c;
  logic [NUM_REQ-1:0] owner_onehot_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .any_c    (pick_any_c),
    .winner_c (pick_id_c)
  );

  // Priority moves to the requester just after the one that was served.
  assign ptr_next_c     = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign owner_onehot_c = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;

  // Scheduler FSM; status outputs are updated together with the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      owner  <= '0;
      ptr    <= '0;
      cnt    <= '0;
      gnt_q  <= '0;
      busy_q <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any_c) begin
            owner  <= pick_id_c;
            cnt    <= CW'(SETUP_CYCLES - 1);
            state  <= ST_SETUP;
            busy_q <= 1'b1;
            idle_q <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt   <= CW'(HOLD_CYCLES - 1);
            state <= ST_GRANT;
            gnt_q <= owner_onehot_c;
          end
        end
        ST_GRANT: begin
          if (done || (cnt == '0)) begin
            state  <= ST_IDLE;
            ptr    <= ptr_next_c;
            gnt_q  <= '0;
            busy_q <= 1'b0;
            idle_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = owner;
  assign busy   = busy_q;
  assign idle   = idle_q;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Bench for rr_grant_sched: two instances (default hold, hold of 4) share
// stimulus; a sequence-level model predicts every output each cycle, and
// directed phases pin literal grant timing and ordering.
module tb_rr_grant_sched;

  localparam int unsigned NREQ = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic       done;

  logic [3:0] gnt0, gnt1;
  logic [1:0] id0, id1;
  logic       busy0, busy1, idle0, idle1;

  int total = 0;
  int bad   = 0;

  rr_grant_sched #(.NUM_REQ(4), .SETUP_CYCLES(2), .HOLD_CYCLES(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .gnt(gnt0), .gnt_id(id0), .busy(busy0), .idle(idle0)
  );

  rr_grant_sched #(.NUM_REQ(4), .SETUP_CYCLES(2), .HOLD_CYCLES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .gnt(gnt1), .gnt_id(id1), .busy(busy1), .idle(idle1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is "age" cycles old; ages [0, S) are setup, [S, S+H) grant.
  int unsigned sc [2] = '{2, 2};
  int unsigned hc [2] = '{1, 4};
  bit          m_in_seq [2];
  int unsigned m_age    [2];
  int unsigned m_owner  [2];
  int unsigned m_ptr    [2];
  bit          m_valid = 1'b0;

  task automatic model_step(input int i);
    bit found;
    if (!reset_n) begin
      m_in_seq[i] = 1'b0;
      m_age[i]    = 0;
      m_owner[i]  = 0;
      m_ptr[i]    = 0;
    end else if (!m_in_seq[i]) begin
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int unsigned c;
        c = (m_ptr[i] + k) % NREQ;
        if (!found && req[c]) begin
          found       = 1'b1;
          m_owner[i]  = c;
          m_in_seq[i] = 1'b1;
          m_age[i]    = 0;
        end
      end
    end else if (m_age[i] >= sc[i] && (done || m_age[i] == sc[i] + hc[i] - 1)) begin
      m_in_seq[i] = 1'b0;
      m_ptr[i]    = (m_owner[i] + 1) % NREQ;
    end else begin
      m_age[i] = m_age[i] + 1;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    if (!reset_n) m_valid = 1'b1;
  end

  task automatic cmp(input int i, input logic [3:0] g, input logic [1:0] id,
                     input logic b, input logic idl);
    logic [3:0] eg;
    eg = (m_in_seq[i] && m_age[i] >= sc[i]) ? (4'b0001 << m_owner[i]) : 4'b0000;
    chk($sformatf("gnt[%0d]", i), 32'(g), 32'(eg));
    chk($sformatf("gnt_id[%0d]", i), 32'(id), m_owner[i]);
    chk($sformatf("busy[%0d]", i), 32'(b), 32'(m_in_seq[i]));
    chk($sformatf("idle[%0d]", i), 32'(idl), 32'(!m_in_seq[i]));
    chk($sformatf("onehot0[%0d]", i), 32'($onehot0(g)), 32'd1);
    chk($sformatf("gnt_implies_busy[%0d]", i), 32'((g == 4'b0) || b), 32'd1);
    chk($sformatf("idle_not_busy[%0d]", i), 32'(idl), 32'(!b));
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp(0, gnt0, id0, busy0, idle0);
      cmp(1, gnt1, id1, busy1, idle1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    req     = 4'b0;
    done    = 1'b0;
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
  endtask

  int rec_id [16];
  int rec_t  [16];
  int nrec;

  // Record dut0 grants over n cycles (owner id and cycle number).
  task automatic collect(input int n);
    nrec = 0;
    for (int c = 1; c <= n; c++) begin
      tick(1);
      if (gnt0 != 4'b0 && nrec < 16) begin
        rec_id[nrec] = int'(id0);
        rec_t[nrec]  = c;
        nrec++;
      end
    end
  endtask

  int exp_order [4];

  initial begin
    reset_n = 1'b0;
    req     = 4'b0;
    done    = 1'b0;
    tick(2);

    // Reset state.
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_id0", 32'(id0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_idle0", 32'(idle0), 1);
    chk("rst_idle1", 32'(idle1), 1);

    // Single requester held: 3 busy cycles, 1 grant cycle, period 4.
    reset_n = 1'b1;
    req     = 4'b0001;
    tick(1); chk("t1_idle_n1", 32'(idle0), 0); chk("t1_gnt_n1", 32'(gnt0), 0);
    tick(1); chk("t1_idle_n2", 32'(idle0), 0); chk("t1_gnt_n2", 32'(gnt0), 0);
    tick(1); chk("t1_gnt_n3", 32'(gnt0), 4'b0001); chk("t1_id_n3", 32'(id0), 0);
    tick(1); chk("t1_gnt_n4", 32'(gnt0), 0); chk("t1_idle_n4", 32'(idle0), 1);
    tick(1); chk("t1_idle_n5", 32'(idle0), 0);
    tick(2); chk("t1_gnt_n7", 32'(gnt0), 4'b0001);
    tick(1); chk("t1_idle_n8", 32'(idle0), 1);
    req = 4'b0;
    tick(10);

    // All requesting: order 0,1,2,3,0, four cycles apart.
    pulse_reset();
    req = 4'b1111;
    collect(20);
    chk("t2_count", nrec, 5);
    chk("t2_first_t", rec_t[0], 3);
    for (int j = 0; j < 5 && j < nrec; j++) begin
      chk($sformatf("t2_id%0d", j), rec_id[j], j % 4);
      if (j > 0) chk($sformatf("t2_gap%0d", j), rec_t[j] - rec_t[j-1], 4);
    end
    req = 4'b0;
    tick(10);

    // Requesters 1 and 3 only: alternate 1,3,1,3.
    pulse_reset();
    req = 4'b1010;
    collect(16);
    exp_order = '{1, 3, 1, 3};
    chk("t3_count", nrec, 4);
    for (int j = 0; j < 4 && j < nrec; j++)
      chk($sformatf("t3_id%0d", j), rec_id[j], exp_order[j]);
    req = 4'b0;
    tick(10);

    // Hold of 4 with done on the second grant cycle; next search from 3.
    pulse_reset();
    req = 4'b0100;
    tick(1); req = 4'b0;
    tick(1);
    tick(1); chk("t4_gnt1_g1", 32'(gnt1), 4'b0100);
    tick(1); chk("t4_gnt1_g2", 32'(gnt1), 4'b0100);
    done = 1'b1;
    req  = 4'b1101;
    tick(1); chk("t4_gnt1_rel", 32'(gnt1), 0); chk("t4_idle1_rel", 32'(idle1), 1);
    done = 1'b0;
    tick(1); chk("t4_busy1", 32'(busy1), 1); chk("t4_id1_next", 32'(id1), 3);
    req = 4'b0;
    tick(12);

    // One-cycle request still served; request raised in GRANT waits for IDLE.
    pulse_reset();
    req = 4'b0001;
    tick(1); req = 4'b0;
    tick(2); chk("t5_gnt0", 32'(gnt0), 4'b0001);
    req = 4'b1000;
    tick(1); chk("t5_gnt_idle", 32'(gnt0), 0); chk("t5_idle", 32'(idle0), 1);
    tick(1); chk("t5_busy", 32'(busy0), 1); chk("t5_id", 32'(id0), 3);
    tick(2); chk("t5_gnt3", 32'(gnt0), 4'b1000);
    req = 4'b0;
    tick(12);

    // Reset during GRANT of owner 2: no partial grant, ptr back to 0.
    pulse_reset();
    req = 4'b0100;
    tick(3); chk("t6_gnt2", 32'(gnt0), 4'b0100); chk("t6_id2", 32'(id0), 2);
    reset_n = 1'b0;
    tick(1); chk("t6_gnt_rst", 32'(gnt0), 0); chk("t6_idle_rst", 32'(idle0), 1);
    reset_n = 1'b1;
    req     = 4'b0101;
    tick(1); chk("t6_busy", 32'(busy0), 1); chk("t6_id0", 32'(id0), 0);
    tick(2); chk("t6_gnt0", 32'(gnt0), 4'b0001);
    req = 4'b0;
    tick(12);

    // Random traffic with early releases and sporadic resets.
    for (int c = 0; c < 2000; c++) begin
      req     = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      done    = ($urandom_range(0, 3) == 0);
      reset_n = ($urandom_range(0, 63) != 0);
      tick(1);
    end
    reset_n = 1'b1;
    req     = 4'b0;
    done    = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
